// File: rtl/ram_rd_arbiter_if.sv
// ram_rd_arbiter_if: requester lanes and RAM read-channel pins of ram_rd_arbiter.
interface ram_rd_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid, req_ready, rsp_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0]         ram_addrb, ram_addrc;
    logic                      ram_enb, ram_enc, ram_regceb, ram_regcec;
    logic [DATA_W-1:0]         ram_doutb, ram_doutc;

    modport master (
        output req_valid, req_addr, ram_doutb, ram_doutc,
        input  req_ready, rsp_valid, rsp_data, ram_addrb, ram_addrc,
               ram_enb, ram_enc, ram_regceb, ram_regcec
    );
    modport slave (
        input  req_valid, req_addr, ram_doutb, ram_doutc,
        output req_ready, rsp_valid, rsp_data, ram_addrb, ram_addrc,
               ram_enb, ram_enc, ram_regceb, ram_regcec
    );
endinterface

// File: rtl/ram_rd_arbiter.sv
// ram_rd_arbiter: round-robin scheduler sharing RAM read channels B and C among NUM_REQ requesters.
// Define RAM_RDARB_STAT_EN to build per-requester saturating grant counters.
module ram_rd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic             clka,
    input  logic             rstb,
    ram_rd_arbiter_if.slave  bus,
    input  logic [2:0]       stat_sel,
    input  logic             stat_clr,
    output logic [15:0]      stat_cnt
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]                 rr_q, rr_d, id_b, id_c, id_last;
    logic                            blk_q, gnt_b, gnt_c;
    logic [ADDR_W-1:0]               addr_b, addr_c;
    logic [RD_LATENCY-1:0]           vb_q, vc_q;
    logic [RD_LATENCY-1:0][ID_W-1:0] ib_q, ic_q;
    logic                            vb_l, vc_l;
    logic [ID_W-1:0]                 ib_l, ic_l;

    // grants are held off in the reset cycle and the one after it
    always_comb begin
        int j;
        j = 0;
        gnt_b = 1'b0;
        gnt_c = 1'b0;
        id_b = '0;
        id_c = '0;
        addr_b = '0;
        addr_c = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (bus.req_valid[j] && !rstb && !blk_q) begin
                if (!gnt_b) begin
                    gnt_b = 1'b1;
                    id_b = ID_W'(j);
                    addr_b = bus.req_addr[j*ADDR_W +: ADDR_W];
                end else if (!gnt_c) begin
                    gnt_c = 1'b1;
                    id_c = ID_W'(j);
                    addr_c = bus.req_addr[j*ADDR_W +: ADDR_W];
                end
            end
        end
        id_last = gnt_c ? id_c : id_b;
        rr_d = !gnt_b ? rr_q : (id_last == ID_W'(NUM_REQ-1)) ? '0 : id_last + 1'b1;
    end

    always_ff @(posedge clka) begin
        blk_q <= rstb;
        ib_q <= (RD_LATENCY*ID_W)'({ib_q, id_b});
        ic_q <= (RD_LATENCY*ID_W)'({ic_q, id_c});
        if (rstb) begin
            rr_q <= '0;
            vb_q <= '0;
            vc_q <= '0;
        end else begin
            rr_q <= rr_d;
            vb_q <= RD_LATENCY'({vb_q, gnt_b});
            vc_q <= RD_LATENCY'({vc_q, gnt_c});
        end
    end

    assign vb_l = vb_q[RD_LATENCY-1] && !rstb;
    assign vc_l = vc_q[RD_LATENCY-1] && !rstb;
    assign ib_l = ib_q[RD_LATENCY-1];
    assign ic_l = ic_q[RD_LATENCY-1];

    assign bus.ram_enb    = gnt_b;
    assign bus.ram_enc    = gnt_c;
    assign bus.ram_addrb  = addr_b;
    assign bus.ram_addrc  = addr_c;
    assign bus.ram_regceb = (RD_LATENCY > 1) && !rstb && vb_q[0];
    assign bus.ram_regcec = (RD_LATENCY > 1) && !rstb && vc_q[0];

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.rsp_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = (gnt_b && id_b == ID_W'(i)) || (gnt_c && id_c == ID_W'(i));
            bus.rsp_valid[i] = (vb_l && ib_l == ID_W'(i)) || (vc_l && ic_l == ID_W'(i));
            bus.rsp_data[i*DATA_W +: DATA_W] = (vb_l && ib_l == ID_W'(i)) ? bus.ram_doutb :
                                               (vc_l && ic_l == ID_W'(i)) ? bus.ram_doutc : '0;
        end
    end

`ifdef RAM_RDARB_STAT_EN
    logic [NUM_REQ-1:0][15:0] cnt_q;

    always_ff @(posedge clka) begin
        for (int i = 0; i < NUM_REQ; i++)
            cnt_q[i] <= (rstb || stat_clr) ? 16'h0 :
                        (bus.req_ready[i] && cnt_q[i] != 16'hFFFF) ? cnt_q[i] + 16'd1 : cnt_q[i];
    end

    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (stat_sel == 3'(i)) stat_cnt = cnt_q[i];
    end
`else
    logic unused_stat;
    assign unused_stat = ^{stat_sel, stat_clr};
    assign stat_cnt = '0;
`endif
endmodule

// File: tb/tb_ram_rd_arbiter.sv
// tb_ram_rd_arbiter: directed vectors for ram_rd_arbiter at RD_LATENCY 1 and 2 against a block-RAM model.
module tb_ram_rd_arbiter;
    logic        clka = 1'b0;
    logic        rstb = 1'b1;
    logic [2:0]  stat_sel = 3'd0;
    logic        stat_clr = 1'b0;
    logic [15:0] stat_cnt, stat_cnt2;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clka = ~clka;

    ram_rd_arbiter_if #(.NUM_REQ(4), .ADDR_W(4), .DATA_W(32)) bus ();
    ram_rd_arbiter_if #(.NUM_REQ(4), .ADDR_W(4), .DATA_W(32)) bus2 ();

    ram_rd_arbiter #(.NUM_REQ(4), .ADDR_W(4), .DATA_W(32), .RD_LATENCY(1)) dut (
        .clka(clka), .rstb(rstb), .bus(bus),
        .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_cnt(stat_cnt)
    );
    ram_rd_arbiter #(.NUM_REQ(4), .ADDR_W(4), .DATA_W(32), .RD_LATENCY(2)) dut2 (
        .clka(clka), .rstb(rstb), .bus(bus2),
        .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_cnt(stat_cnt2)
    );

    function automatic logic [31:0] mem(logic [3:0] a);
        return 32'hA0000000 + {28'h0, a};
    endfunction

    function automatic logic [127:0] ln(int i, logic [3:0] a);
        return {96'h0, mem(a)} << (i*32);
    endfunction

    // RAM model: LOW_LATENCY for bus, HIGH_PERFORMANCE (extra output register) for bus2
    logic [31:0] db, dc, db1, dc1, db2, dc2;
    always @(posedge clka) begin
        if (bus.ram_enb) db <= mem(bus.ram_addrb);
        if (bus.ram_enc) dc <= mem(bus.ram_addrc);
        if (bus2.ram_enb) db1 <= mem(bus2.ram_addrb);
        if (bus2.ram_enc) dc1 <= mem(bus2.ram_addrc);
        if (bus2.ram_regceb) db2 <= db1;
        if (bus2.ram_regcec) dc2 <= dc1;
    end
    assign bus.ram_doutb  = db;
    assign bus.ram_doutc  = dc;
    assign bus2.ram_doutb = db2;
    assign bus2.ram_doutc = dc2;

    typedef struct {
        logic         rst;
        logic [3:0]   vld;
        logic [15:0]  addr;
        logic [3:0]   rdy;
        logic         enb;
        logic [3:0]   ab;
        logic         enc;
        logic [3:0]   ac;
        logic [3:0]   rv;
        logic [127:0] rd;
    } vec_t;

    vec_t tv[21];

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_addr = '0;
        bus2.req_valid = '0;
        bus2.req_addr = '0;
        //          rst   vld    addr      rdy    enb   ab     enc   ac     rv     rd
        tv[0]  = '{1'b1, 4'h0, 16'h0000, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, '0};
        tv[1]  = '{1'b0, 4'hF, 16'h3210, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, '0};
        tv[2]  = '{1'b0, 4'h1, 16'h0003, 4'h1, 1'b1, 4'h3, 1'b0, 4'h0, 4'h0, '0};
        tv[3]  = '{1'b0, 4'h8, 16'h7000, 4'h8, 1'b1, 4'h7, 1'b0, 4'h0, 4'h1, ln(0, 4'h3)};
        tv[4]  = '{1'b0, 4'hF, 16'h3210, 4'h3, 1'b1, 4'h0, 1'b1, 4'h1, 4'h8, ln(3, 4'h7)};
        tv[5]  = '{1'b0, 4'hF, 16'h3210, 4'hC, 1'b1, 4'h2, 1'b1, 4'h3, 4'h3, ln(0, 4'h0) | ln(1, 4'h1)};
        tv[6]  = '{1'b0, 4'hF, 16'h3210, 4'h3, 1'b1, 4'h0, 1'b1, 4'h1, 4'hC, ln(2, 4'h2) | ln(3, 4'h3)};
        tv[7]  = '{1'b0, 4'hF, 16'h3210, 4'hC, 1'b1, 4'h2, 1'b1, 4'h3, 4'h3, ln(0, 4'h0) | ln(1, 4'h1)};
        tv[8]  = '{1'b0, 4'h0, 16'h3210, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'hC, ln(2, 4'h2) | ln(3, 4'h3)};
        tv[9]  = '{1'b0, 4'h2, 16'h3210, 4'h2, 1'b1, 4'h1, 1'b0, 4'h0, 4'h0, '0};
        tv[10] = '{1'b0, 4'hA, 16'h3210, 4'hA, 1'b1, 4'h3, 1'b1, 4'h1, 4'h2, ln(1, 4'h1)};
        tv[11] = '{1'b0, 4'hA, 16'h3210, 4'hA, 1'b1, 4'h3, 1'b1, 4'h1, 4'hA, ln(1, 4'h1) | ln(3, 4'h3)};
        tv[12] = '{1'b0, 4'h0, 16'h3210, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'hA, ln(1, 4'h1) | ln(3, 4'h3)};
        tv[13] = '{1'b0, 4'h4, 16'h0F00, 4'h4, 1'b1, 4'hF, 1'b0, 4'h0, 4'h0, '0};
        tv[14] = '{1'b0, 4'h9, 16'h5009, 4'h9, 1'b1, 4'h5, 1'b1, 4'h9, 4'h4, ln(2, 4'hF)};
        tv[15] = '{1'b0, 4'h0, 16'h5009, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h9, ln(3, 4'h5) | ln(0, 4'h9)};
        tv[16] = '{1'b0, 4'h2, 16'h0060, 4'h2, 1'b1, 4'h6, 1'b0, 4'h0, 4'h0, '0};
        tv[17] = '{1'b1, 4'h2, 16'h0060, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, '0};
        tv[18] = '{1'b0, 4'hF, 16'h3210, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, '0};
        tv[19] = '{1'b0, 4'hF, 16'h3210, 4'h3, 1'b1, 4'h0, 1'b1, 4'h1, 4'h0, '0};
        tv[20] = '{1'b0, 4'h0, 16'h3210, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h3, ln(0, 4'h0) | ln(1, 4'h1)};

        for (int i = 0; i < 21; i++) begin
            step();
            rstb = tv[i].rst;
            bus.req_valid = tv[i].vld;
            bus.req_addr = tv[i].addr;
            @(negedge clka);
            chk($sformatf("v%0d req_ready", i), 128'(bus.req_ready), 128'(tv[i].rdy));
            chk($sformatf("v%0d chan_b", i), 128'({bus.ram_enb, bus.ram_addrb}), 128'({tv[i].enb, tv[i].ab}));
            chk($sformatf("v%0d chan_c", i), 128'({bus.ram_enc, bus.ram_addrc}), 128'({tv[i].enc, tv[i].ac}));
            chk($sformatf("v%0d regce", i), 128'({bus.ram_regceb, bus.ram_regcec}), 128'(0));
            chk($sformatf("v%0d rsp_valid", i), 128'(bus.rsp_valid), 128'(tv[i].rv));
            chk($sformatf("v%0d rsp_data", i), bus.rsp_data, tv[i].rd);
        end

        // RD_LATENCY=2: regce in T+1, response in T+2
        step();
        bus.req_valid = '0;
        bus2.req_valid = 4'h4;
        bus2.req_addr = 16'h0F00;
        @(negedge clka);
        chk("lat2 T ready", 128'(bus2.req_ready), 128'(4'h4));
        chk("lat2 T chan_b", 128'({bus2.ram_enb, bus2.ram_addrb, bus2.ram_enc}), 128'({1'b1, 4'hF, 1'b0}));
        chk("lat2 T regceb", 128'(bus2.ram_regceb), 128'(0));
        step();
        bus2.req_valid = '0;
        @(negedge clka);
        chk("lat2 T+1 regce", 128'({bus2.ram_regceb, bus2.ram_regcec}), 128'(2'b10));
        chk("lat2 T+1 rsp_valid", 128'(bus2.rsp_valid), 128'(0));
        step();
        @(negedge clka);
        chk("lat2 T+2 rsp_valid", 128'(bus2.rsp_valid), 128'(4'h4));
        chk("lat2 T+2 rsp_data", bus2.rsp_data, ln(2, 4'hF));
        chk("lat2 T+2 regceb", 128'(bus2.ram_regceb), 128'(0));
        step();
        @(negedge clka);
        chk("lat2 T+3 rsp_valid", 128'(bus2.rsp_valid), 128'(0));

`ifdef RAM_RDARB_STAT_EN
        stat_sel = 3'd1;
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        @(negedge clka);
        chk("stat cleared", 128'(stat_cnt), 128'(0));
        for (int i = 0; i < 5; i++) begin
            step();
            bus.req_valid = 4'h2;
        end
        step();
        bus.req_valid = '0;
        @(negedge clka);
        chk("stat count 5", 128'(stat_cnt), 128'(5));
        stat_sel = 3'd5;
        #1;
        chk("stat sel out of range", 128'(stat_cnt), 128'(0));
        stat_sel = 3'd1;
        step();
        stat_clr = 1'b1;
        bus.req_valid = 4'h2;
        step();
        stat_clr = 1'b0;
        bus.req_valid = '0;
        @(negedge clka);
        chk("stat clr beats incr", 128'(stat_cnt), 128'(0));
        step();
        dut.cnt_q[1] = 16'hFFFE;
        bus.req_valid = 4'h2;
        step();
        step();
        bus.req_valid = '0;
        @(negedge clka);
        chk("stat saturate", 128'(stat_cnt), 128'(16'hFFFF));
`else
        stat_sel = 3'd1;
        stat_clr = 1'b0;
        step();
        bus.req_valid = 4'h2;
        step();
        bus.req_valid = '0;
        @(negedge clka);
        chk("stat tied 0 sel1", 128'(stat_cnt), 128'(0));
        stat_sel = 3'd0;
        #1;
        chk("stat tied 0 sel0", 128'(stat_cnt), 128'(0));
        chk("stat2 tied 0", 128'(stat_cnt2), 128'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ram_rd_arbiter.md
# ram_rd_arbiter

Round-robin read scheduler that shares the two read channels (B and C) of the team's dual-read-port block RAM among NUM_REQ requesters in one clock domain. Each cycle it grants up to two requesters, one per channel, and drives the RAM read address and enable pins. It routes each returned word back to the requester that issued it, with a fixed latency that matches the RAM's output-register setting. It sits between client engines (lookup and table-scan logic) and the RAM instance; the RAM write port is not touched.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- ADDR_W, 4: RAM address width
- DATA_W, 32: RAM data width
- RD_LATENCY, 1: 1 = RAM built LOW_LATENCY; 2 = RAM built HIGH_PERFORMANCE

- clka  in  1  clock; the RAM's clkb and clkc are tied to it
- rstb  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  read request per requester
- req_addr  in  NUM_REQ*ADDR_W  request address; lane i is bits [i*ADDR_W +: ADDR_W]
- req_ready  out  NUM_REQ  request accepted this cycle
- rsp_valid  out  NUM_REQ  response pulse per requester
- rsp_data  out  NUM_REQ*DATA_W  response data lane per requester
- ram_addrb, ram_addrc  out  ADDR_W each  read addresses to RAM channels B and C
- ram_enb, ram_enc  out  1 each  read enables
- ram_regceb, ram_regcec  out  1 each  output-register enables; used only when RD_LATENCY=2
- ram_doutb, ram_doutc  in  DATA_W each  RAM read data
- stat_sel  in  3  requester index for statistics readout
- stat_clr  in  1  clears all statistics counters
- stat_cnt  out  16  grant count of requester stat_sel

## Operation
- Handshake: valid/ready. A request transfers in the cycle where req_valid[i] && req_ready[i]. req_ready is combinational from req_valid and rr_ptr.
- Arbitration: scan indices rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - First valid requester gets channel B; second valid requester gets channel C.
  - Any further valid requesters wait. One requester never receives both channels in the same cycle.
- Pointer update:
  - If at least one grant: rr_ptr <= (index of last granted) + 1 mod NUM_REQ.
  - If no grant: rr_ptr holds.
- RAM drive:
  - ram_enb = B granted; ram_addrb = granted address, 0 when idle. Channel C is identical.
- Tag pipeline: one {valid, id} shift register per channel, depth RD_LATENCY.
  - With RD_LATENCY=2: ram_regceb = valid of tag B stage 1; ram_regcec = valid of tag C stage 1.
  - With RD_LATENCY=1: ram_regceb and ram_regcec = 0.
- Response:
  - At the last tag stage with valid set, rsp_valid[id] = 1 and lane id of rsp_data = that channel's dout.
  - Lanes with no response are driven 0.
  - B and C never target the same id in one cycle, so no lane collision can occur.
- State: rr_ptr, tag pipelines and statistics counters. There is no other FSM.

## Timing
- Grant in cycle T gives rsp_valid in cycle T+RD_LATENCY, exactly one cycle wide.
- Sustained throughput is 2 reads/cycle. With all requesters valid, each requester gets at least 2 grants per NUM_REQ cycles.
- Reset values:
  - rr_ptr = 0; all tags invalid; counters = 0.
  - Outputs: req_ready, rsp_valid, rsp_data, ram_en*, ram_regce* and ram_addr* = 0 during the reset cycle and the cycle after it.
  - req_ready is forced 0 while rstb = 1.
- Reset mid-operation: in-flight reads are dropped and no rsp_valid is issued for them. Requesters must re-issue.
- Wrap-around: scanning and rr_ptr wrap from NUM_REQ-1 to 0.
- Only one requester valid: that requester gets channel B; channel C stays idle.
- A requester may issue back-to-back requests every cycle. Responses return in issue order.

## Configuration
- Macro RAM_RDARB_STAT_EN.
- Defined:
  - One 16-bit saturating grant counter per requester, incremented on each accepted request.
  - A counter holds at 0xFFFF once it saturates.
  - stat_clr = 1 zeroes all counters next cycle and takes priority over increment.
  - stat_cnt = counter[stat_sel], combinational. stat_sel >= NUM_REQ reads 0.
- Undefined: no counters are built; stat_cnt is tied to 0; stat_sel and stat_clr are ignored. Ports remain present in both cases.

## Test plan
All scenarios use NUM_REQ=4, ADDR_W=4, DATA_W=32, with the RAM preloaded mem[a] = 32'hA0000000 + a.
- Single request: req0 at addr 3, RD_LATENCY=1 → req_ready[0] in T, ram_enb=1 with ram_addrb=3 in T, rsp_valid[0]=1 with lane0 = 32'hA0000003 in T+1, rsp_valid otherwise 0.
- All four valid for 4 cycles, addr = requester index → grants {0B,1C}, {2B,3C}, {0B,1C}, {2B,3C}; each requester gets 2 responses with the correct data.
- Requesters 1 and 3 only, rr_ptr = 2 → grant 3 on B and 1 on C; rr_ptr becomes 2.
- RD_LATENCY=2, req2 at addr 15 → ram_regceb=1 in T+1, rsp_valid[2] with 32'hA000000F in T+2.
- rstb pulsed in T+1 after a grant in T → no rsp_valid; rr_ptr=0; first grant after reset goes to requester 0.
- With RAM_RDARB_STAT_EN defined: req1 granted 5 times, then stat_sel=1 → stat_cnt=5; stat_clr → 0; preload 0xFFFE and grant twice → 0xFFFF. With the macro undefined: stat_cnt=0 throughout.
